// File: rtl/collision_monitor.sv
// Scans one obstacle box per cycle against the character box, tracks lives with a
// post-hit grace window, and holds a lose state until acknowledged.
module collision_monitor #(
  parameter int COORD_W      = 10,
  parameter int NUM_OBS      = 4,
  parameter int LIVES        = 3,
  parameter int GRACE_CYCLES = 16,
  localparam int LW = $clog2(LIVES + 1),
  localparam int IW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1
) (
  input  logic                       Clk,
  input  logic                       reset,
  input  logic                       Start,
  input  logic                       Ack,
  input  logic [COORD_W-1:0]         Char_X_L,
  input  logic [COORD_W-1:0]         Char_X_R,
  input  logic [COORD_W-1:0]         Char_Y_T,
  input  logic [COORD_W-1:0]         Char_Y_B,
  input  logic [NUM_OBS*COORD_W-1:0] Obs_X_L,
  input  logic [NUM_OBS*COORD_W-1:0] Obs_X_R,
  input  logic [NUM_OBS*COORD_W-1:0] Obs_Y_T,
  input  logic [NUM_OBS*COORD_W-1:0] Obs_Y_B,
  input  logic [NUM_OBS-1:0]         Obs_Valid,
  output logic                       Q_Initial,
  output logic                       Q_Check,
  output logic                       Q_Hit,
  output logic                       Q_Lose,
  output logic [LW-1:0]              Lives_Left,
  output logic [IW-1:0]              Hit_Index,
  output logic [7:0]                 Hit_Count
);

  localparam int GW = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;

  localparam logic [3:0] ST_INIT = 4'b0001;
  localparam logic [3:0] ST_SCAN = 4'b0010;
  localparam logic [3:0] ST_HIT  = 4'b0100;
  localparam logic [3:0] ST_LOSE = 4'b1000;

  logic [3:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [IW-1:0] hit_idx_q, hit_idx_d;
  logic [7:0]    hit_cnt_q, hit_cnt_d;
  logic [GW-1:0] grace_q, grace_d;

  logic [COORD_W-1:0] obs_xl_s [NUM_OBS];
  logic [COORD_W-1:0] obs_xr_s [NUM_OBS];
  logic [COORD_W-1:0] obs_yt_s [NUM_OBS];
  logic [COORD_W-1:0] obs_yb_s [NUM_OBS];
  logic               overlap_s;
  logic               hit_s;
  logic [LW-1:0]      lives_dec_s;

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_unpack
    assign obs_xl_s[g] = Obs_X_L[g*COORD_W +: COORD_W];
    assign obs_xr_s[g] = Obs_X_R[g*COORD_W +: COORD_W];
    assign obs_yt_s[g] = Obs_Y_T[g*COORD_W +: COORD_W];
    assign obs_yb_s[g] = Obs_Y_B[g*COORD_W +: COORD_W];
  end

  // Strict compares: boxes that only share an edge do not collide.
  assign overlap_s   = (Char_X_R > obs_xl_s[idx_q]) && (Char_X_L < obs_xr_s[idx_q]) &&
                       (Char_Y_B > obs_yt_s[idx_q]) && (Char_Y_T < obs_yb_s[idx_q]);
  assign hit_s       = Obs_Valid[idx_q] && overlap_s;
  assign lives_dec_s = lives_q - LW'(1);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      lives_q   <= LW'(LIVES);
      hit_idx_q <= '0;
      hit_cnt_q <= 8'd0;
      grace_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lives_q   <= lives_d;
      hit_idx_q <= hit_idx_d;
      hit_cnt_q <= hit_cnt_d;
      grace_q   <= grace_d;
    end
  end

  always_comb begin
    state_d   = ST_INIT;
    idx_d     = idx_q;
    lives_d   = lives_q;
    hit_idx_d = hit_idx_q;
    hit_cnt_d = hit_cnt_q;
    grace_d   = grace_q;
    case (state_q)
      ST_INIT: begin
        idx_d   = '0;
        lives_d = LW'(LIVES);
        if (Start) state_d = ST_SCAN;
        else       state_d = ST_INIT;
      end
      ST_SCAN: begin
        if (hit_s) begin
          hit_idx_d = idx_q;
          lives_d   = lives_dec_s;
          if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
          else                    hit_cnt_d = hit_cnt_q;
          grace_d   = GW'(GRACE_CYCLES - 1);
          if (lives_dec_s == LW'(0)) state_d = ST_LOSE;
          else                       state_d = ST_HIT;
        end else begin
          if (idx_q == IW'(NUM_OBS - 1)) idx_d = '0;
          else                           idx_d = idx_q + IW'(1);
          state_d = ST_SCAN;
        end
      end
      ST_HIT: begin
        if (grace_q == GW'(0)) begin
          idx_d   = '0;
          state_d = ST_SCAN;
        end else begin
          grace_d = grace_q - GW'(1);
          state_d = ST_HIT;
        end
      end
      ST_LOSE: begin
        if (Ack) state_d = ST_INIT;
        else     state_d = ST_LOSE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    Q_Initial  = state_q[0];
    Q_Check    = state_q[1];
    Q_Hit      = state_q[2];
    Q_Lose     = state_q[3];
    Lives_Left = lives_q;
    Hit_Index  = hit_idx_q;
    Hit_Count  = hit_cnt_q;
  end

endmodule
